// File: rtl/finish_scheduler_pkg.sv
// finish_sched_pkg: shared FSM state type and sizing helpers for the
// diagonal finish scheduler.
package finish_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Narrowest index width handed out by idx_w, even for a 1-entry range.
  localparam int MIN_IDX_W = 1;

  // Number of anti-diagonals in a rows x cols array.
  function automatic int diag_n(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Width of a counter that must reach n-1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : MIN_IDX_W;
  endfunction

endpackage

// File: rtl/finish_scheduler_if.sv
// finish_scheduler_if: start/ready job handshake plus finish/done outputs.
// The abort input exists only when FINISH_SCHED_ABORT_EN is defined.
interface finish_scheduler_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_W  = 8,
  parameter int T_W  = 8
);
  logic                 start;
  logic [K_W-1:0]       k_len;
  logic [T_W-1:0]       n_tiles;
  logic                 ready;
  logic                 busy;
  logic [ROWS*COLS-1:0] finish;
  logic                 done;
`ifdef FINISH_SCHED_ABORT_EN
  logic                 abort;
`endif

  // Tile controller side.
  modport master (
`ifdef FINISH_SCHED_ABORT_EN
    output abort,
`endif
    output start, k_len, n_tiles,
    input  ready, busy, finish, done
  );

  // Scheduler side.
  modport slave (
`ifdef FINISH_SCHED_ABORT_EN
    input  abort,
`endif
    input  start, k_len, n_tiles,
    output ready, busy, finish, done
  );

endinterface

// File: rtl/finish_scheduler_wave_shift.sv
// wave_shift: diagonal delay line. diag[0] takes the launch pulse, every
// stage moves up by one per cycle; flush empties all in-flight wavefronts.
module wave_shift #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         launch,
  input  logic         flush,
  output logic [N-1:0] diag
);

  logic [N-1:0] shift_next;

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign shift_next[gi] = launch;
    end else begin : g_body
      assign shift_next[gi] = diag[gi-1];
    end
  end

  // Advance the wavefronts one diagonal per cycle, or drop them all.
  always_ff @(posedge clk) begin
    if (rst || flush) diag <= '0;
    else              diag <= shift_next;
  end

endmodule

// File: rtl/finish_scheduler.sv
// finish_scheduler: issues per-PE finish pulses skewed by r+c for a job of
// n_tiles back-to-back tiles of k_len cycles each, and pulses done when the
// last PE of the last tile finishes.
// Optional feature macro: FINISH_SCHED_ABORT_EN (adds bus.abort).
module finish_scheduler
  import finish_sched_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_W  = 8,
  parameter int T_W  = 8
) (
  input logic               clk,
  input logic               rst,
  finish_scheduler_if.slave bus
);

  localparam int D  = diag_n(ROWS, COLS);
  localparam int DW = idx_w(D);
  localparam bit SINGLE = (D == 1);
  // Drain lasts D-1 cycles after the last launch cycle.
  localparam logic [DW-1:0] DRAIN_LAST = DW'((D >= 2) ? D - 2 : 0);

  state_t         state_reg, state_next;
  logic [K_W-1:0] k_len_reg, k_len_next;
  logic [T_W-1:0] n_tiles_reg, n_tiles_next;
  logic [K_W-1:0] k_cnt_reg, k_cnt_next;
  logic [T_W-1:0] t_cnt_reg, t_cnt_next;
  logic [DW-1:0]  drain_cnt_reg, drain_cnt_next;
  logic [D-1:0]   diag;
  logic           accept, at_launch, last_tile, launch_in, flush, abort_req, done_int;

`ifdef FINISH_SCHED_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  assign bus.ready = (state_reg == S_IDLE) && !rst;
  assign bus.busy  = (state_reg != S_IDLE);
  assign accept    = bus.start && bus.ready;
  // In RUN this is the cycle in which the current tile's wave sits in diag[0].
  assign at_launch = (k_cnt_reg == k_len_reg - K_W'(1));
  assign last_tile = (t_cnt_reg == n_tiles_reg - T_W'(1));
  assign flush     = abort_req && (state_reg != S_IDLE);
  assign bus.done  = done_int && !rst;

  // Next-state, counter update and launch look-ahead.
  always_comb begin
    state_next     = state_reg;
    k_len_next     = k_len_reg;
    n_tiles_next   = n_tiles_reg;
    k_cnt_next     = k_cnt_reg;
    t_cnt_next     = t_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    done_int       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next   = S_RUN;
          k_len_next   = (bus.k_len == '0) ? K_W'(1) : bus.k_len;
          n_tiles_next = (bus.n_tiles == '0) ? T_W'(1) : bus.n_tiles;
          k_cnt_next   = '0;
          t_cnt_next   = '0;
        end
      end
      S_RUN: begin
        if (at_launch) begin
          k_cnt_next = '0;
          t_cnt_next = t_cnt_reg + T_W'(1);
          if (last_tile) begin
            drain_cnt_next = '0;
            if (SINGLE) begin
              state_next = S_IDLE;
              done_int   = 1'b1;
            end else begin
              state_next = S_DRAIN;
            end
          end
        end else begin
          k_cnt_next = k_cnt_reg + K_W'(1);
        end
      end
      S_DRAIN: begin
        drain_cnt_next = drain_cnt_reg + DW'(1);
        if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = S_IDLE;
          done_int   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
      done_int   = 1'b0;
    end
    // diag[0] is registered, so it is loaded one cycle ahead of the launch cycle.
    launch_in = (state_next == S_RUN) && (k_cnt_next == k_len_next - K_W'(1));
  end

  // State, latched job parameters and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      k_len_reg     <= '0;
      n_tiles_reg   <= '0;
      k_cnt_reg     <= '0;
      t_cnt_reg     <= '0;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      k_len_reg     <= k_len_next;
      n_tiles_reg   <= n_tiles_next;
      k_cnt_reg     <= k_cnt_next;
      t_cnt_reg     <= t_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  wave_shift #(.N(D)) u_wave (
    .clk    (clk),
    .rst    (rst),
    .launch (launch_in),
    .flush  (flush),
    .diag   (diag)
  );

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      assign bus.finish[gi*COLS+gj] = diag[gi+gj];
    end
  end

endmodule

// File: tb/tb_finish_scheduler.sv
// tb_finish_scheduler: directed checks of finish skew, overlap, zero-input
// handling, held start, reset mid-job and (when enabled) abort.
module tb_finish_scheduler;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NPE  = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [NPE-1:0] fin_log  [0:63];
  logic           done_log [0:63];
  logic           rdy_log  [0:63];
  logic           busy_log [0:63];

  always #5 clk = ~clk;

  finish_scheduler_if #(.ROWS(ROWS), .COLS(COLS), .K_W(8), .T_W(8)) bus ();

  finish_scheduler #(.ROWS(ROWS), .COLS(COLS), .K_W(8), .T_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pulses(input int lo, input int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) s += $countones(fin_log[c]);
    return s;
  endfunction

  function automatic int bit_pulses(input int b, input int lo, input int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) s += int'(fin_log[c][b]);
    return s;
  endfunction

  function automatic int dones(input int lo, input int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) s += int'(done_log[c]);
    return s;
  endfunction

  function automatic int readies(input int lo, input int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) s += int'(rdy_log[c]);
    return s;
  endfunction

  // Accept a job in cycle 0 and log outputs for cycles 1..ncyc.
  task automatic run_job(input int k, input int n, input int ncyc, input bit hold,
                         input int rst_at, input int abort_at);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.k_len   = 8'(k);
    bus.n_tiles = 8'(n);
    chk("accept_ready", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      fin_log[c]  = bus.finish;
      done_log[c] = bus.done;
      rdy_log[c]  = bus.ready;
      busy_log[c] = bus.busy;
      if (c == rst_at) rst = 1'b1;
      if (c == rst_at + 1) rst = 1'b0;
`ifdef FINISH_SCHED_ABORT_EN
      if (c == abort_at) bus.abort = 1'b1;
      if (c == abort_at + 1) bus.abort = 1'b0;
`endif
    end
    $display("job k=%0d n=%0d logged %0d cycles", k, n, ncyc);
  endtask

  initial begin
    int seen;
    bus.start   = 1'b0;
    bus.k_len   = '0;
    bus.n_tiles = '0;
`ifdef FINISH_SCHED_ABORT_EN
    bus.abort   = 1'b0;
`endif
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_finish", 32'(bus.finish), 32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_ready",  32'(bus.ready),  32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(bus.ready), 32'd1);

    // k_len=8, n_tiles=1.
    run_job(8, 1, 20, 1'b0, -1, -1);
    chk("k8_busy_c1",  32'(busy_log[1]),   32'd1);
    chk("k8_pe0_c7",   32'(fin_log[7][0]), 32'd0);
    chk("k8_pe0_c8",   32'(fin_log[8][0]), 32'd1);
    chk("k8_pe5_c10",  32'(fin_log[10][5]), 32'd1);
    chk("k8_pe15_c14", 32'(fin_log[14][15]), 32'd1);
    chk("k8_done_c14", 32'(done_log[14]), 32'd1);
    chk("k8_done_cnt", 32'(dones(1, 20)), 32'd1);
    chk("k8_rdy_c14",  32'(rdy_log[14]), 32'd0);
    chk("k8_rdy_c15",  32'(rdy_log[15]), 32'd1);
    chk("k8_pulses",   32'(pulses(1, 20)), 32'd16);

    // k_len=2, n_tiles=3: overlapping wavefronts.
    run_job(2, 3, 14, 1'b0, -1, -1);
    chk("k2_pe0_c2",  32'(fin_log[2][0]), 32'd1);
    chk("k2_pe0_c3",  32'(fin_log[3][0]), 32'd0);
    chk("k2_pe0_c4",  32'(fin_log[4][0]), 32'd1);
    chk("k2_pe0_c6",  32'(fin_log[6][0]), 32'd1);
    chk("k2_pe0_cnt", 32'(bit_pulses(0, 1, 14)), 32'd3);
    chk("k2_pe15_c8", 32'(fin_log[8][15]), 32'd1);
    chk("k2_pe15_c10", 32'(fin_log[10][15]), 32'd1);
    chk("k2_pe15_c12", 32'(fin_log[12][15]), 32'd1);
    chk("k2_pe15_cnt", 32'(bit_pulses(15, 1, 14)), 32'd3);
    chk("k2_done_c12", 32'(done_log[12]), 32'd1);
    chk("k2_done_cnt", 32'(dones(1, 14)), 32'd1);
    chk("k2_pulses",   32'(pulses(1, 14)), 32'd48);

    // Zero inputs behave as 1/1.
    run_job(0, 0, 10, 1'b0, -1, -1);
    chk("k0_pe0_c1",  32'(fin_log[1][0]), 32'd1);
    chk("k0_done_c7", 32'(done_log[7]), 32'd1);
    chk("k0_done_cnt", 32'(dones(1, 10)), 32'd1);
    chk("k0_rdy_c8",  32'(rdy_log[8]), 32'd1);
    chk("k0_pulses",  32'(pulses(1, 10)), 32'd16);

    // start held high: one accept, next accept right after done.
    run_job(2, 1, 10, 1'b1, -1, -1);
    bus.start = 1'b0;
    chk("hold_done_c8",  32'(done_log[8]), 32'd1);
    chk("hold_rdy_1to8", 32'(readies(1, 8)), 32'd0);
    chk("hold_rdy_c9",   32'(rdy_log[9]), 32'd1);
    chk("hold_busy_c10", 32'(busy_log[10]), 32'd1);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("hold_second_done", 32'(seen), 32'd1);

    // Reset in cycle 5 of a k_len=8 job.
    run_job(8, 1, 20, 1'b0, 5, -1);
    chk("rst_mid_busy_c6", 32'(busy_log[6]), 32'd0);
    chk("rst_mid_rdy_c6",  32'(rdy_log[6]), 32'd0);
    chk("rst_mid_rdy_c7",  32'(rdy_log[7]), 32'd1);
    chk("rst_mid_pulses",  32'(pulses(6, 20)), 32'd0);
    chk("rst_mid_done",    32'(dones(1, 20)), 32'd0);

`ifdef FINISH_SCHED_ABORT_EN
    // Abort during DRAIN (cycle 11 of a k_len=8 job).
    run_job(8, 1, 18, 1'b0, -1, 11);
    chk("abort_busy_c11",  32'(busy_log[11]), 32'd1);
    chk("abort_pulses_pre", 32'(pulses(1, 11)), 32'd10);
    chk("abort_fin_c12",   32'(fin_log[12]), 32'd0);
    chk("abort_pulses_post", 32'(pulses(12, 18)), 32'd0);
    chk("abort_done",      32'(dones(1, 18)), 32'd0);
    chk("abort_rdy_c12",   32'(rdy_log[12]), 32'd1);

    // abort together with start in IDLE: start wins.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    bus.k_len   = 8'd1;
    bus.n_tiles = 8'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_idle_busy", 32'(bus.busy), 32'd1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort_idle_done", 32'(seen), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
